mem_sram_bridge: RTL and testbench

MEM_SRAM_BRIDGE -- requirements
Module: mem_sram_bridge

---
 rtl/mem_sram_bridge.sv | 122 ++++++++++++
 tb/tb_mem_sram_bridge.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_sram_bridge.sv
// Bridges a single-issue MEM-stage access onto an sram-like bus with one
// transaction in flight; results are held until the pipeline advances.
//
//  state | meaning
//  IDLE  | no access in progress; a cpu_req is latched here
//  ADDR  | data_req driven, waiting for data_addr_ok
//  DATA  | request accepted, waiting for data_data_ok
//  HOLD  | result (or alignment error) presented until the pipeline moves
module mem_sram_bridge (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_pipe_stall,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_addr_err,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic [31:0] data_rdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [1:0]  req_size;
    logic        misaligned;

    // Size 3 is folded into a word access before alignment is judged.
    assign req_size   = (cpu_size == 2'd3) ? 2'd2 : cpu_size;
    assign misaligned = ((req_size == 2'd1) && cpu_addr[0]) ||
                        ((req_size == 2'd2) && (cpu_addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    wr_d    = cpu_wr;
                    size_d  = req_size;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = HOLD;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                if (data_addr_ok) state_d = DATA;
            end
            DATA: begin
                // Stores finish on the write response too; only loads update rdata.
                if (data_data_ok) begin
                    if (!wr_q) rdata_d = data_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!cpu_pipe_stall) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_req     = (state_q == ADDR);
    assign data_wr      = wr_q;
    assign data_size    = size_q;
    assign data_addr    = addr_q;
    assign data_wdata   = wdata_q;
    assign cpu_rdata    = rdata_q;
    assign cpu_stall    = ((state_q == IDLE) && cpu_req) || (state_q == ADDR) ||
                          (state_q == DATA);
    assign cpu_addr_err = (state_q == HOLD) && err_q;

endmodule

// File: tb/tb_mem_sram_bridge.sv
// Directed bench for mem_sram_bridge: load, stalled store, misaligned access,
// external pipeline stall, reset mid-transaction and size-3 folding.
module tb_mem_sram_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_req, cpu_wr, cpu_pipe_stall;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall, cpu_addr_err;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;

    int n_chk  = 0;
    int n_fail = 0;

    mem_sram_bridge dut (
        .clk            (clk),
        .resetn         (resetn),
        .cpu_req        (cpu_req),
        .cpu_wr         (cpu_wr),
        .cpu_size       (cpu_size),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_pipe_stall (cpu_pipe_stall),
        .cpu_rdata      (cpu_rdata),
        .cpu_stall      (cpu_stall),
        .cpu_addr_err   (cpu_addr_err),
        .data_req       (data_req),
        .data_wr        (data_wr),
        .data_size      (data_size),
        .data_addr      (data_addr),
        .data_wdata     (data_wdata),
        .data_rdata     (data_rdata),
        .data_addr_ok   (data_addr_ok),
        .data_data_ok   (data_data_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_size = 2'd0;
        cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_pipe_stall = 1'b0;
        data_rdata = 32'd0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #12;
        check("rst_stall",   32'(cpu_stall), 32'h0);
        check("rst_err",     32'(cpu_addr_err), 32'h0);
        check("rst_req",     32'(data_req), 32'h0);
        check("rst_wr",      32'(data_wr), 32'h0);
        check("rst_size",    32'(data_size), 32'h0);
        check("rst_addr",    data_addr, 32'h0);
        check("rst_wdata",   data_wdata, 32'h0);
        check("rst_rdata",   cpu_rdata, 32'h0);
        cpu_req = 1'b1; settle();
        check("rst_stall_req", 32'(cpu_stall), 32'h1);
        cpu_req = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        tick();

        // Aligned load, minimum latency
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h1000_0004; settle();
        check("ld_t0_stall", 32'(cpu_stall), 32'h1);
        check("ld_t0_req",   32'(data_req), 32'h0);
        tick(); data_addr_ok = 1'b1; settle();
        check("ld_t1_req",   32'(data_req), 32'h1);
        check("ld_t1_addr",  data_addr, 32'h1000_0004);
        check("ld_t1_size",  32'(data_size), 32'h2);
        check("ld_t1_wr",    32'(data_wr), 32'h0);
        check("ld_t1_stall", 32'(cpu_stall), 32'h1);
        tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF; settle();
        check("ld_t2_req",   32'(data_req), 32'h0);
        check("ld_t2_stall", 32'(cpu_stall), 32'h1);
        tick(); data_data_ok = 1'b0; settle();
        check("ld_t3_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("ld_t3_stall", 32'(cpu_stall), 32'h0);
        check("ld_t3_err",   32'(cpu_addr_err), 32'h0);
        check("ld_t3_req",   32'(data_req), 32'h0);
        tick(); cpu_req = 1'b0; settle();
        check("ld_t4_stall", 32'(cpu_stall), 32'h0);

        // Store with 4 cycles of address backpressure
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_size = 2'd0; cpu_addr = 32'h2000_0003;
        cpu_wdata = 32'hAA00_0000; settle();
        check("st_t0_stall", 32'(cpu_stall), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick(); settle();
            check("st_bp_req",   32'(data_req), 32'h1);
            check("st_bp_addr",  data_addr, 32'h2000_0003);
            check("st_bp_wdata", data_wdata, 32'hAA00_0000);
            check("st_bp_size",  32'(data_size), 32'h0);
            check("st_bp_wr",    32'(data_wr), 32'h1);
        end
        tick(); data_addr_ok = 1'b1; settle();
        check("st_ok_req", 32'(data_req), 32'h1);
        tick(); data_addr_ok = 1'b0; settle();
        check("st_data_req",   32'(data_req), 32'h0);
        check("st_data_stall", 32'(cpu_stall), 32'h1);
        tick(); settle();
        check("st_wait_stall", 32'(cpu_stall), 32'h1);
        data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        tick(); data_data_ok = 1'b0; settle();
        check("st_hold_stall", 32'(cpu_stall), 32'h0);
        check("st_hold_rdata", cpu_rdata, 32'hDEAD_BEEF);
        tick(); cpu_req = 1'b0; settle();

        // Misaligned word
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h3000_0002; settle();
        check("mis_t0_stall", 32'(cpu_stall), 32'h1);
        tick(); settle();
        check("mis_t1_req",   32'(data_req), 32'h0);
        check("mis_t1_stall", 32'(cpu_stall), 32'h0);
        check("mis_t1_err",   32'(cpu_addr_err), 32'h1);
        tick(); cpu_req = 1'b0; settle();
        check("mis_t2_err",   32'(cpu_addr_err), 32'h0);
        check("mis_t2_req",   32'(data_req), 32'h0);

        // Misaligned half goes straight to HOLD with the error flag
        cpu_req = 1'b1; cpu_size = 2'd1; cpu_addr = 32'h3000_0001;
        tick(); settle();
        check("mish_err",   32'(cpu_addr_err), 32'h1);
        check("mish_stall", 32'(cpu_stall), 32'h0);
        tick(); cpu_req = 1'b0; settle();

        // Aligned half load with external stall over HOLD
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = 2'd1; cpu_addr = 32'h4000_0008;
        tick(); data_addr_ok = 1'b1; settle();
        check("xs_req", 32'(data_req), 32'h1);
        tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        cpu_pipe_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); data_data_ok = 1'b0; settle();
            check("xs_hold_stall", 32'(cpu_stall), 32'h0);
            check("xs_hold_req",   32'(data_req), 32'h0);
            check("xs_hold_rdata", cpu_rdata, 32'hCAFE_F00D);
        end
        tick(); cpu_pipe_stall = 1'b0; settle();
        check("xs_rel_stall", 32'(cpu_stall), 32'h0);
        // New access presented right after HOLD must be accepted as such
        tick(); cpu_addr = 32'h6000_0010; cpu_size = 2'd2; settle();
        check("xs_idle_stall", 32'(cpu_stall), 32'h1);
        tick(); data_addr_ok = 1'b1; settle();
        check("new_req",  32'(data_req), 32'h1);
        check("new_addr", data_addr, 32'h6000_0010);
        tick(); data_addr_ok = 1'b0; settle();
        check("new_data_stall", 32'(cpu_stall), 32'h1);

        // Reset pulse in DATA, then a late data_ok
        resetn = 1'b0; #2; resetn = 1'b1;
        cpu_req = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5555_5555; settle();
        check("rmid_rdata", cpu_rdata, 32'h0);
        check("rmid_req",   32'(data_req), 32'h0);
        check("rmid_addr",  data_addr, 32'h0);
        check("rmid_stall", 32'(cpu_stall), 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick(); settle();
            check("late_rdata", cpu_rdata, 32'h0);
            check("late_req",   32'(data_req), 32'h0);
            check("late_stall", 32'(cpu_stall), 32'h0);
        end
        data_data_ok = 1'b0;

        // Size 3 folds to a word store
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_size = 2'd3; cpu_addr = 32'h5000_0004;
        cpu_wdata = 32'h0102_0304;
        tick(); data_addr_ok = 1'b1; settle();
        check("sz3_size",  32'(data_size), 32'h2);
        check("sz3_wdata", data_wdata, 32'h0102_0304);
        tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h9999_9999;
        tick(); data_data_ok = 1'b0; settle();
        check("sz3_hold_stall", 32'(cpu_stall), 32'h0);
        check("sz3_hold_rdata", cpu_rdata, 32'h0);
        tick(); cpu_req = 1'b0; settle();
        check("end_stall", 32'(cpu_stall), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
